// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller: forwarding-mux
// encodings, the scoreboard entry layout and the producer/consumer match rule.
package hazard_pkg;

  localparam logic [1:0] FWD_IDREG = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } sb_entry_t;

  // x0 is hardwired, so it never names a real producer.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] rs,
                                    input logic use_rs);
    return e.vld & e.wr & (e.rd == rs) & (rs != 5'd0) & use_rs;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry (EX/MEM/WB) shift register shadowing the pipeline registers;
// a bubble empties the EX slot, a squash empties both EX and MEM slots.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  sb_entry_t id_entry,
  input  logic      bubble,
  input  logic      squash,
  output sb_entry_t ex_e,
  output sb_entry_t mem_e,
  output sb_entry_t wb_e
);

  // NOTE: non-blocking assignments so every stage samples its predecessor's
  // pre-edge value; blocking here would collapse the shift into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_e  <= '0;
      mem_e <= '0;
      wb_e  <= '0;
    end else begin
      wb_e  <= mem_e;
      mem_e <= squash ? '0 : ex_e;
      ex_e  <= (squash || bubble) ? '0 : id_entry;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard unit for the 5-stage RISC-V pipeline: load-use / no-forward stalls,
// redirect flushes, EX operand forwarding selects and saturating event counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             redirect_i,
  output logic             pc_write_en_o,
  output logic             if_id_write_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  sb_entry_t id_entry, ex_e, mem_e, wb_e;
  logic      id_u1, id_u2;
  logic      stall_raw, stall;
  logic      unused_bits;

  function automatic logic [1:0] pick(input sb_entry_t m, input sb_entry_t w,
                                      input logic [4:0] rs, input logic use_rs);
    if (sb_match(m, rs, use_rs))      return FWD_EXMEM;
    else if (sb_match(w, rs, use_rs)) return FWD_MEMWB;
    else                              return FWD_IDREG;
  endfunction

  assign id_u1 = id_valid_i & id_use_rs1_i;
  assign id_u2 = id_valid_i & id_use_rs2_i;

  assign id_entry = '{vld: id_valid_i, rd: id_rd_i,
                      wr: id_reg_write_i & (id_rd_i != 5'd0), ld: id_mem_read_i,
                      rs1: id_rs1_i, rs2: id_rs2_i, u1: id_use_rs1_i, u2: id_use_rs2_i};

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .id_entry (id_entry),
    .bubble   (stall),
    .squash   (redirect_i),
    .ex_e     (ex_e),
    .mem_e    (mem_e),
    .wb_e     (wb_e)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    stall_raw = 1'b0;
    if (FWD_EN != 0)
      stall_raw = (sb_match(ex_e, id_rs1_i, id_u1) | sb_match(ex_e, id_rs2_i, id_u2))
                  & ex_e.ld;
    else
      stall_raw = sb_match(ex_e,  id_rs1_i, id_u1) | sb_match(ex_e,  id_rs2_i, id_u2) |
                  sb_match(mem_e, id_rs1_i, id_u1) | sb_match(mem_e, id_rs2_i, id_u2);
  end

  // A redirect discards the stalled instruction anyway, so it overrides the stall.
  assign stall = stall_raw & ~redirect_i;

  assign pc_write_en_o    = ~stall;
  assign if_id_write_en_o = ~stall;
  assign if_id_flush_o    = redirect_i;
  assign id_ex_flush_o    = redirect_i | stall;
  assign ex_mem_flush_o   = redirect_i;

  always_comb begin
    fwd_a_sel_o = FWD_IDREG;
    fwd_b_sel_o = FWD_IDREG;
    if (FWD_EN != 0 && ex_e.vld) begin
      fwd_a_sel_o = pick(mem_e, wb_e, ex_e.rs1, ex_e.u1);
      fwd_b_sel_o = pick(mem_e, wb_e, ex_e.rs2, ex_e.u2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall && stall_cnt_o != {CNT_W{1'b1}})
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (redirect_i && flush_cnt_o != {CNT_W{1'b1}})
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

  // Operand tags and load flags of the later stages have no consumer here.
  assign unused_bits = ^{mem_e.ld, mem_e.rs1, mem_e.rs2, mem_e.u1, mem_e.u2,
                         wb_e.ld, wb_e.rs1, wb_e.rs2, wb_e.u1, wb_e.u2};

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: a cycle-by-cycle vector table for the forwarding build plus
// hand sequences for no-forward stalls, redirect-in-stall, saturation and reset.
module tb_pipeline_hazard_controller;

  localparam logic [8:0] IDLE  = 9'h180;
  localparam logic [8:0] STALL = 9'h020;
  localparam logic [8:0] REDIR = 9'h1F0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        pc1, ifidwe1, ifidfl1, idexfl1, exmemfl1;
  logic [1:0]  fa1, fb1;
  logic [15:0] scnt1, fcnt1;
  logic        pc0, ifidwe0, ifidfl0, idexfl0, exmemfl0;
  logic [1:0]  fa0, fb0;
  logic [3:0]  scnt0, fcnt0;

  wire [8:0] outs1 = {pc1, ifidwe1, ifidfl1, idexfl1, exmemfl1, fa1, fb1};
  wire [8:0] outs0 = {pc0, ifidwe0, ifidfl0, idexfl0, exmemfl0, fa0, fb0};

  pipeline_hazard_controller #(.FWD_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .redirect_i(redirect),
    .pc_write_en_o(pc1), .if_id_write_en_o(ifidwe1), .if_id_flush_o(ifidfl1),
    .id_ex_flush_o(idexfl1), .ex_mem_flush_o(exmemfl1), .fwd_a_sel_o(fa1),
    .fwd_b_sel_o(fb1), .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1));

  pipeline_hazard_controller #(.FWD_EN(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .redirect_i(redirect),
    .pc_write_en_o(pc0), .if_id_write_en_o(ifidwe0), .if_id_flush_o(ifidfl0),
    .id_ex_flush_o(idexfl0), .ex_mem_flush_o(exmemfl0), .fwd_a_sel_o(fa0),
    .fwd_b_sel_o(fb0), .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0));

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, ld, redir;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [23];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic ld, input logic redir,
                              input logic [8:0] exp);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
    t.rd = rd; t.rw = rw; t.ld = ld; t.redir = redir; t.exp = exp;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    id_rd = t.rd; id_reg_write = t.rw; id_mem_read = t.ld; redirect = t.redir;
  endtask

  task automatic nop();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    nop();
    // Forwarding build, one row per cycle; expectations track EX/MEM/WB by hand.
    tbl[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, IDLE);    // add x5,x1,x2
    tbl[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, IDLE);    // add x6,x5,x1
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h184);  // x6 in EX, x5 in MEM: A=01
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    tbl[4]  = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, IDLE);    // lw x5,0(x1)
    tbl[5]  = mk(1, 1, 5, 1, 1, 6, 1, 0, 0, STALL);   // add x6,x1,x5: load-use
    tbl[6]  = mk(1, 1, 5, 1, 1, 6, 1, 0, 0, IDLE);    // held copy proceeds
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h182);  // load in WB: B=10
    tbl[8]  = mk(1, 1, 2, 1, 1, 0, 1, 0, 0, IDLE);    // add x0,x1,x2
    tbl[9]  = mk(1, 0, 0, 1, 1, 6, 1, 0, 0, IDLE);    // add x6,x0,x0
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);    // x0 never forwarded
    tbl[11] = mk(1, 1, 2, 1, 1, 7, 1, 0, 0, IDLE);    // add x7,x1,x2
    tbl[12] = mk(1, 3, 4, 1, 1, 7, 1, 0, 0, IDLE);    // add x7,x3,x4
    tbl[13] = mk(1, 7, 7, 1, 1, 8, 1, 0, 0, IDLE);    // add x8,x7,x7
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h185);  // younger x7 (MEM) wins
    tbl[15] = mk(1, 1, 1, 1, 1, 9, 1, 0, 0, IDLE);    // add x9,x1,x1
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    tbl[17] = mk(1, 9, 9, 1, 0, 10, 1, 0, 0, IDLE);   // rs2 field unused
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h188);  // A=10, B stays 00
    tbl[19] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, IDLE);    // lw x5
    tbl[20] = mk(1, 5, 1, 1, 1, 6, 1, 0, 1, REDIR);   // redirect beats stall
    tbl[21] = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, IDLE);    // squashed load gone
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);    // nothing in WB to forward

    do_reset();
    @(negedge clk);
    check("reset_outs_fwd1", outs1, IDLE);
    check("reset_outs_fwd0", outs0, IDLE);
    check("reset_cnt_fwd1", {scnt1, fcnt1}, 32'h0);
    check("reset_cnt_fwd0", {scnt0, fcnt0}, 32'h0);
    tick();

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      check($sformatf("row%0d", i), outs1, tbl[i].exp);
      tick();
    end
    nop();
    @(negedge clk);
    check("table_stall_cnt", scnt1, 1);
    check("table_flush_cnt", fcnt1, 1);

    // No-forward build: back-to-back dependency costs two bubbles.
    do_reset();
    apply(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, IDLE));
    @(negedge clk); check("nofwd_producer", outs0, IDLE); tick();
    apply(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, IDLE));
    @(negedge clk); check("nofwd_stall1", outs0, STALL); tick();
    @(negedge clk); check("nofwd_stall2", outs0, STALL); tick();
    @(negedge clk); check("nofwd_release", outs0, IDLE); tick();
    nop();
    @(negedge clk);
    check("nofwd_stall_cnt", scnt0, 2);
    check("nofwd_sels", {fa0, fb0}, 0);

    // Redirect arriving in the load-use stall cycle.
    do_reset();
    apply(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, IDLE));
    @(negedge clk); check("rs_load", outs1, IDLE); tick();
    apply(mk(1, 1, 5, 1, 1, 6, 1, 0, 1, REDIR));
    @(negedge clk); check("rs_redirect", outs1, REDIR); tick();
    nop();
    @(negedge clk);
    check("rs_after", outs1, IDLE);
    check("rs_flush_cnt", fcnt1, 1);
    check("rs_stall_cnt", scnt1, 0);

    // Saturation on the 4-bit counters: self-dependent add stalls 2 of every 3 cycles.
    do_reset();
    apply(mk(1, 5, 5, 1, 1, 5, 1, 0, 0, IDLE));
    repeat (12) tick();
    @(negedge clk); check("sat_stall_partial", scnt0, 8);
    repeat (30) tick();
    @(negedge clk); check("sat_stall_hold", scnt0, 4'hF);
    redirect = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("sat_flush_hold", fcnt0, 4'hF);
    check("sat_stall_frozen", scnt0, 4'hF);

    // Reset while a stall is being asserted.
    do_reset();
    apply(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, IDLE));
    tick();
    apply(mk(1, 1, 5, 1, 1, 6, 1, 0, 0, IDLE));
    @(negedge clk);
    check("mid_stall", outs1, STALL);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nop();
    @(negedge clk);
    check("post_reset_outs", outs1, IDLE);
    check("post_reset_cnt", {scnt1, fcnt1}, 32'h0);
    tick();
    @(negedge clk);
    check("post_reset_idle", outs1, IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
